// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   muldiv_op_t : operation select encoding (matches the 2-bit op port)
//   state_t     : control FSM states
//   WORD_W      : architectural word width
package muldiv_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: accumulator plus one shift/add (multiply) or restoring
// shift/subtract (divide) step per enabled cycle. Operands are unsigned
// magnitudes; sign handling lives in the top level.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : clear accumulator high half, load A into low half, capture B
//   i_step   : perform one iteration
//   i_div    : 1 = divide step, 0 = multiply step
//   i_a, i_b : operand magnitudes
//   o_acc    : multiply -> 2*WIDTH product; divide -> {remainder, quotient}
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  always_comb begin
    // Multiply: multiplier sits in the low half and is consumed LSB first;
    // the carry out of the add shifts back into the product.
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the partial remainder; the
    // low half doubles as dividend (shifting out) and quotient (shifting in).
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_b});
    // When w_ge holds the true difference is below r_b, so the low bits suffice.
    w_diff     = w_shift[WIDTH-1:0] - r_b;
    w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= i_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO.
// Start is accepted in IDLE or DONE; WIDTH CALC cycles, one FIX cycle that
// applies sign correction and writes HI/LO, then a one-cycle DONE pulse.
//   clk, rst     : clock, synchronous active-high reset
//   start, op    : launch request and operation select
//   srcA, srcB   : operands (rs and ALU-input mux output)
//   mthi, mtlo   : write srcA into HI / LO (IDLE or DONE only)
//   hi, lo       : architectural HI/LO
//   busy         : CALC or FIX
//   done         : one-cycle pulse when HI/LO hold the new result
//   div_by_zero  : valid with done; divisor was zero
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t             r_state;
  muldiv_op_t         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_lo;   // negate product / quotient
  logic               r_neg_hi;   // remainder takes the dividend's sign
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_open;
  logic               w_accept;
  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_is_div;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = start && w_open;
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_sign_a = w_signed && srcA[WIDTH-1];
  assign w_sign_b = w_signed && srcB[WIDTH-1];
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  assign w_mag_a  = w_sign_a ? (~srcA + 1'b1) : srcA;
  assign w_mag_b  = w_sign_b ? (~srcB + 1'b1) : srcB;
  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_step (r_state == S_CALC),
    .i_div  (w_is_div),
    .i_a    (w_mag_a),
    .i_b    (w_mag_b),
    .o_acc  (w_acc)
  );

  // Sign correction for the FIX edge. With a zero divisor the remainder
  // path ends up holding |A|, so restoring A's sign yields srcA as sampled;
  // only LO needs forcing.
  always_comb begin
    w_prod = r_neg_lo ? (~w_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_acc;
    w_quot = r_neg_lo ? (~w_acc[WIDTH-1:0] + 1'b1) : w_acc[WIDTH-1:0];
    w_rem  = r_neg_hi ? (~w_acc[2*WIDTH-1:WIDTH] + 1'b1) : w_acc[2*WIDTH-1:WIDTH];
    if (r_dbz) begin
      w_quot = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MULT;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Move-to writes land now; a coincident start overwrites them at FIX.
          if (mthi) r_hi <= srcA;
          if (mtlo) r_lo <= srcA;
          if (w_accept) begin
            r_op     <= muldiv_op_t'(op);
            r_neg_lo <= w_sign_a ^ w_sign_b;
            r_neg_hi <= w_sign_a;
            r_dbz    <= op[1] && (srcB == '0);
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = (r_state == S_DONE) && r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized transactions against a plain
// arithmetic reference model of HI/LO; one line printed per transaction.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp;
  int n_err;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .srcA        (srcA),
    .srcB        (srcB),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      sa, sb, sq, sr, sp;
    logic [63:0] up, tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        sp  = sa * sb;
        tmp = sp;
        eh  = tmp[63:32];
        el  = tmp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          ed = 1'b1;
          eh = a;
          el = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          sq  = sa / sb;
          sr  = sa % sb;
          tmp = sq;
          el  = tmp[31:0];
          tmp = sr;
          eh  = tmp[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Called at a negedge; start is presented for one cycle (cycle 0).
  // disturb: mtlo at cycle 5 and a new start at cycle 10, both to be ignored.
  // with_mt: mtlo coincides with the accepted start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_mt);
    int          c, done_c, busy_n;
    logic [31:0] eh, el;
    logic        ed;
    model(o, a, b, eh, el, ed);
    start = 1'b1; op = o; srcA = a; srcB = b; mtlo = with_mt;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    if (with_mt) begin
      chk("mt_with_start", {32'd0, lo}, {32'd0, a});
      m_lo = a;
    end
    c = 1; done_c = 0; busy_n = 0;
    while (done_c == 0 && c < 100) begin
      if (busy) busy_n++;
      if (c == 20) begin
        chk("hold_hi", {32'd0, hi}, {32'd0, m_hi});
        chk("hold_lo", {32'd0, lo}, {32'd0, m_lo});
      end
      if (done) begin
        done_c = c;
      end else begin
        if (disturb && c == 5) begin mtlo = 1'b1; srcA = 32'h5555_AAAA; end
        if (disturb && c == 6) mtlo = 1'b0;
        if (disturb && c == 10) begin start = 1'b1; op = 2'b01; srcA = 32'd9; srcB = 32'd11; end
        if (disturb && c == 11) start = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    chk("done_cycle", 64'(done_c), 64'd34);
    chk("busy_cycles", 64'(busy_n), 64'd33);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("hi", {32'd0, hi}, {32'd0, eh});
    chk("lo", {32'd0, lo}, {32'd0, el});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
    m_hi = eh;
    m_lo = el;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d done@%0d", o, a, b, hi, lo, div_by_zero, done_c);
  endtask

  initial begin
    int          seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0; mthi = 1'b0; mtlo = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    $display("reset: hi=%h lo=%h busy=%0d done=%0d", hi, lo, busy, done);

    // Directed cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    // mthi + mtlo together while idle.
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; srcA = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mt_both_lo", {32'd0, lo}, 64'h1234_5678);
    m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;
    $display("mthi+mtlo: hi=%h lo=%h", hi, lo);

    // mtlo coincident with start, then disturbed MULTU 3*4.
    run_op(2'b00, 32'd6, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_op(2'b01, 32'd3, 32'd4, 1'b1, 1'b0);

    // mthi during the DONE cycle.
    mthi = 1'b1; srcA = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_after_done", {32'd0, hi}, 64'hDEAD_BEEF);
    chk("lo_after_mthi", {32'd0, lo}, 64'd12);
    m_hi = 32'hDEAD_BEEF;
    $display("mthi: hi=%h lo=%h", hi, lo);

    // Randomized transactions; some start in the previous DONE cycle.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        2: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ro, ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = 2'b01; srcA = 32'd77; srcB = 32'd88;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    $display("abort: hi=%h lo=%h busy=%0d", hi, lo, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
